// File: rtl/arb_srl_fifo_enq_pkg.sv
// Shared arbiter package: FSM state encoding and the round-robin priority pick.
// Reused by other round-robin arbiters in the codebase.
package arb_srl_fifo_enq_pkg;

    localparam int unsigned RR_MAX_REQ   = 16;
    localparam int unsigned RR_MAX_IDX_W = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    typedef struct packed {
        logic                    found;
        logic [RR_MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // Rotate valid so ptr sits at bit 0, find the first set bit, then unrotate.
    // Requests at or above n are never candidates; ptr is expected to be < n.
    function automatic rr_pick_t rr_pick_f(
        input logic [RR_MAX_REQ-1:0]   valid,
        input logic [RR_MAX_IDX_W-1:0] ptr,
        input int unsigned             n
    );
        rr_pick_t                res;
        logic [RR_MAX_REQ-1:0]   rot;
        int unsigned             j;
        res = '0;
        rot = '0;
        for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
            j = 32'(ptr) + i;
            if (j >= n) j = j - n;
            if (i < n) rot[i] = valid[RR_MAX_IDX_W'(j)];
        end
        for (int unsigned i = RR_MAX_REQ; i > 0; i--) begin
            if (rot[i-1]) begin
                j = 32'(ptr) + i - 1;
                if (j >= n) j = j - n;
                res.found = 1'b1;
                res.idx   = RR_MAX_IDX_W'(j);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/arb_srl_fifo_enq_if.sv
// Producer-side beat streams plus FIFO enqueue port and arbiter status.
// master = producers/FIFO environment, slave = arbiter.
interface arb_srl_fifo_enq_if #(
    parameter int unsigned width  = 128,
    parameter int unsigned nreq   = 4,
    parameter int unsigned l2nreq = 2
);
    logic [nreq-1:0]       REQ_VALID;
    logic [nreq-1:0]       REQ_EOM;
    logic [nreq*width-1:0] REQ_DATA;
    logic [nreq-1:0]       REQ_READY;
    logic                  FIFO_ENQ;
    logic [width-1:0]      FIFO_DIN;
    logic                  FIFO_FULL_N;
    logic                  LOCKED;
    logic [l2nreq-1:0]     OWNER;

    modport master (
        output REQ_VALID, REQ_EOM, REQ_DATA, FIFO_FULL_N,
        input  REQ_READY, FIFO_ENQ, FIFO_DIN, LOCKED, OWNER
    );

    modport slave (
        input  REQ_VALID, REQ_EOM, REQ_DATA, FIFO_FULL_N,
        output REQ_READY, FIFO_ENQ, FIFO_DIN, LOCKED, OWNER
    );
endinterface

// File: rtl/arb_srl_fifo_enq_rr_pick.sv
// Combinational round-robin pick: first valid request at or after the pointer.
module arb_srl_fifo_enq_rr_pick
    import arb_srl_fifo_enq_pkg::*;
#(
    parameter int unsigned nreq   = 4,
    parameter int unsigned l2nreq = 2
) (
    input  logic [nreq-1:0]   i_valid,
    input  logic [l2nreq-1:0] i_ptr,
    output logic              o_found,
    output logic [l2nreq-1:0] o_idx
);

    rr_pick_t w_res;
    logic     w_unused_idx;

    always_comb begin
        w_res = rr_pick_f(RR_MAX_REQ'(i_valid), RR_MAX_IDX_W'(i_ptr), nreq);
    end

    assign o_found      = w_res.found;
    assign o_idx        = l2nreq'(w_res.idx);
    assign w_unused_idx = ^w_res.idx;

endmodule

// File: rtl/arb_srl_fifo_enq.sv
// Round-robin arbiter sharing one FIFO enqueue port, grant locked per message.
// Define ARB_SRL_FIFO_BEAT_INTERLEAVE_EN for per-beat arbitration (no locking).
module arb_srl_fifo_enq
    import arb_srl_fifo_enq_pkg::*;
#(
    parameter int unsigned width  = 128,
    parameter int unsigned nreq   = 4,
    parameter int unsigned l2nreq = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                CLR,
    arb_srl_fifo_enq_if.slave   bus
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [l2nreq-1:0]  r_rr;
    logic [l2nreq-1:0]  w_rr_nxt;
    logic [l2nreq-1:0]  r_owner;
    logic [l2nreq-1:0]  w_owner_nxt;

    logic               w_pick_found;
    logic [l2nreq-1:0]  w_pick_idx;
    logic [l2nreq-1:0]  w_gnt_idx;
    logic [l2nreq-1:0]  w_gnt_inc;
    logic               w_gnt_valid;
    logic               w_active;
    logic               w_xfer;
    logic [nreq-1:0]    w_ready;
    logic [width-1:0]   w_din;
    logic [width-1:0]   w_slice [nreq];

    arb_srl_fifo_enq_rr_pick #(
        .nreq   (nreq),
        .l2nreq (l2nreq)
    ) u_rr_pick (
        .i_valid (bus.REQ_VALID),
        .i_ptr   (r_rr),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    // Unflatten the producer data bus into per-requester beats.
    always_comb begin
        for (int unsigned k = 0; k < nreq; k++) begin
            w_slice[k] = bus.REQ_DATA[k*width +: width];
        end
    end

    // Reset and clear both suppress any handshake in the cycle they are seen.
    assign w_active = RST_N && !CLR;

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_owner_nxt = r_owner;
        w_gnt_idx   = w_pick_idx;
        w_gnt_valid = w_pick_found;
        w_ready     = '0;
        w_din       = w_slice[r_owner];

        if (r_state == ST_LOCKED) begin
            w_gnt_idx   = r_owner;
            w_gnt_valid = bus.REQ_VALID[r_owner];
        end

        w_gnt_inc = (w_gnt_idx == l2nreq'(nreq - 1)) ? '0 : w_gnt_idx + l2nreq'(1);
        w_xfer    = w_active && w_gnt_valid && bus.FIFO_FULL_N;

        if (w_xfer) begin
            w_ready     = nreq'(1) << w_gnt_idx;
            w_din       = w_slice[w_gnt_idx];
            w_owner_nxt = w_gnt_idx;
`ifdef ARB_SRL_FIFO_BEAT_INTERLEAVE_EN
            w_rr_nxt    = w_gnt_inc;
`else
            if (bus.REQ_EOM[w_gnt_idx]) begin
                w_state_nxt = ST_IDLE;
                w_rr_nxt    = w_gnt_inc;
            end else begin
                w_state_nxt = ST_LOCKED;
            end
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N || CLR) begin
            r_state <= ST_IDLE;
            r_rr    <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    assign bus.REQ_READY = w_ready;
    assign bus.FIFO_ENQ  = w_xfer;
    assign bus.FIFO_DIN  = w_din;
    assign bus.OWNER     = r_owner;

`ifdef ARB_SRL_FIFO_BEAT_INTERLEAVE_EN
    logic w_unused_eom;
    assign w_unused_eom = ^bus.REQ_EOM;
    assign bus.LOCKED   = 1'b0;
`else
    assign bus.LOCKED   = (r_state == ST_LOCKED);
`endif

endmodule
